// File: rtl/l1_req_queue.sv
// Request intake FIFO between the L1 trace driver and the cache controller.
// Registered head-of-queue outputs, address field split, saturating per-command counters.
module l1_req_queue #(
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int CNT_W       = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                L1valid,
  input  logic [1:0]                          L1cmd,
  input  logic [31:0]                         L1addr,
  input  logic [31:0]                         L1data,
  output logic                                stall,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [1:0]                          req_cmd,
  output logic [32-OFFSET_BITS-INDEX_BITS-1:0] req_tag,
  output logic [INDEX_BITS-1:0]               req_index,
  output logic [OFFSET_BITS-1:0]              req_offset,
  output logic [31:0]                         req_data,
  output logic [$clog2(DEPTH):0]              level,
  output logic [CNT_W-1:0]                    rd_cnt,
  output logic [CNT_W-1:0]                    wr_cnt,
  output logic [CNT_W-1:0]                    if_cnt,
  output logic [CNT_W-1:0]                    inv_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             head_q, head_d;
  entry_t             in_s;
  logic               req_valid_q, req_valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   if_cnt_q, if_cnt_d, inv_cnt_q, inv_cnt_d;
  logic               full_s, push_s, pop_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full_s = (level_q == LVL_W'(DEPTH));
  assign stall  = L1valid & ~full_s & ~rst;
  assign push_s = stall;
  assign pop_s  = req_valid_q & req_ready;
  assign in_s   = '{cmd: L1cmd, addr: L1addr, data: L1data};

  // Next-state for storage, pointers, occupancy and the registered head.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    head_d      = head_q;
    req_valid_d = req_valid_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // With one entry left, a same-cycle push lands at the new head slot before memory holds it.
    if (pop_s) begin
      if (level_q == LVL_W'(1)) begin
        if (push_s) begin
          head_d      = in_s;
          req_valid_d = 1'b1;
        end else begin
          head_d      = '0;
          req_valid_d = 1'b0;
        end
      end else begin
        head_d      = mem_q[rd_ptr_d];
        req_valid_d = 1'b1;
      end
    end else if (!req_valid_q && push_s) begin
      head_d      = in_s;
      req_valid_d = 1'b1;
    end else begin
      head_d      = head_q;
      req_valid_d = req_valid_q;
    end
  end

  // Per-command statistics; only accepted pushes count.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if_cnt_d  = if_cnt_q;
    inv_cnt_d = inv_cnt_q;
    if (push_s) begin
      case (L1cmd)
        2'd0:    rd_cnt_d  = sat_inc(rd_cnt_q);
        2'd1:    wr_cnt_d  = sat_inc(wr_cnt_q);
        2'd2:    if_cnt_d  = sat_inc(if_cnt_q);
        2'd3:    inv_cnt_d = sat_inc(inv_cnt_q);
        default: rd_cnt_d  = rd_cnt_q;
      endcase
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      if_cnt_q    <= '0;
      inv_cnt_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      if_cnt_q    <= if_cnt_d;
      inv_cnt_q   <= inv_cnt_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_cmd    = head_q.cmd;
  assign req_tag    = head_q.addr[31:OFFSET_BITS+INDEX_BITS];
  assign req_index  = head_q.addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign req_offset = head_q.addr[OFFSET_BITS-1:0];
  assign req_data   = head_q.data;
  assign level      = level_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign if_cnt     = if_cnt_q;
  assign inv_cnt    = inv_cnt_q;

endmodule

// File: tb/tb_l1_req_queue.sv
// Scoreboard bench for l1_req_queue: directed stimulus queues expected head values,
// a negedge monitor pops and compares on every consumed request.
module tb_l1_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        L1valid, req_ready;
  logic [1:0]  L1cmd;
  logic [31:0] L1addr, L1data;
  logic        stall, req_valid;
  logic [1:0]  req_cmd;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic [31:0] req_data;
  logic [2:0]  level;
  logic [31:0] rd_cnt, wr_cnt, if_cnt, inv_cnt;

  logic        s_valid, s_ready;
  logic [1:0]  s_cmd;
  logic        s_stall, s_req_valid;
  logic [1:0]  s_req_cmd;
  logic [11:0] s_req_tag;
  logic [13:0] s_req_index;
  logic [5:0]  s_req_offset;
  logic [31:0] s_req_data;
  logic [2:0]  s_level;
  logic [2:0]  s_rd_cnt, s_wr_cnt, s_if_cnt, s_inv_cnt;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [11:0] tag;
    logic [13:0] idx;
    logic [5:0]  off;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  always #5 clk = ~clk;

  l1_req_queue #(.DEPTH(4), .OFFSET_BITS(6), .INDEX_BITS(14), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .L1valid(L1valid), .L1cmd(L1cmd), .L1addr(L1addr),
    .L1data(L1data), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_tag(req_tag), .req_index(req_index),
    .req_offset(req_offset), .req_data(req_data), .level(level),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .if_cnt(if_cnt), .inv_cnt(inv_cnt)
  );

  l1_req_queue #(.DEPTH(4), .OFFSET_BITS(6), .INDEX_BITS(14), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .L1valid(s_valid), .L1cmd(s_cmd), .L1addr(32'h0000_0100),
    .L1data(32'h0000_0000), .stall(s_stall), .req_valid(s_req_valid), .req_ready(s_ready),
    .req_cmd(s_req_cmd), .req_tag(s_req_tag), .req_index(s_req_index),
    .req_offset(s_req_offset), .req_data(s_req_data), .level(s_level),
    .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt), .if_cnt(s_if_cnt), .inv_cnt(s_inv_cnt)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && req_valid === 1'b1 && req_ready === 1'b1) begin
      pops++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got cmd=%0h tag=%0h with empty scoreboard", req_cmd, req_tag);
      end else begin
        chk("pop_head", {req_cmd, req_tag, req_index, req_offset, req_data}, sb.pop_front());
      end
    end
  end

  task automatic apply(input logic v, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    @(posedge clk); #1;
    L1valid = v; L1cmd = c; L1addr = a; L1data = d; req_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; L1valid = 1'b0; req_ready = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; L1valid = 1'b0; L1cmd = 2'd0; L1addr = 32'h0; L1data = 32'h0; req_ready = 1'b0;
    s_valid = 1'b0; s_ready = 1'b1; s_cmd = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_level", 96'(level), 96'd0);
    chk("rst_valid", 96'(req_valid), 96'd0);
    chk("rst_stall", 96'(stall), 96'd0);

    // Test 1: reset mid-stream with three queued
    apply(1'b1, 2'd0, 32'h0000_0000, 32'h0000_0001, 1'b0); chk("t1_stall0", 96'(stall), 96'd1);
    apply(1'b1, 2'd1, 32'h0000_0040, 32'h0000_0002, 1'b0); chk("t1_stall1", 96'(stall), 96'd1);
    apply(1'b1, 2'd2, 32'h0000_0080, 32'h0000_0003, 1'b0); chk("t1_stall2", 96'(stall), 96'd1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t1_level3", 96'(level), 96'd3);
    #2 rst = 1'b1; L1valid = 1'b1;
    #1;
    chk("t1_rst_level", 96'(level), 96'd0);
    chk("t1_rst_valid", 96'(req_valid), 96'd0);
    chk("t1_rst_stall", 96'(stall), 96'd0);
    chk("t1_rst_cnts", {rd_cnt, wr_cnt, if_cnt}, 96'd0);
    chk("t1_rst_inv", 96'(inv_cnt), 96'd0);
    chk("t1_rst_head", {req_cmd, req_tag, req_index, req_offset, req_data}, 96'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; L1valid = 1'b0;
    apply(1'b1, 2'd0, 32'h0000_1040, 32'h0000_0000, 1'b0);
    chk("t1_push_stall", 96'(stall), 96'd1);
    sb.push_back('{2'd0, 12'h000, 14'h0041, 6'h00, 32'h0});
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t1_valid", 96'(req_valid), 96'd1);
    chk("t1_fields", {req_tag, req_index, req_offset}, {12'h000, 14'h0041, 6'h00});
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t1_empty", {req_valid, level}, 96'd0);

    // Test 2: fill with backpressure, six request cycles
    do_reset();
    apply(1'b1, 2'd0, 32'h0010_0080, 32'h0000_0011, 1'b0); chk("t2_s0", 96'(stall), 96'd1);
    sb.push_back('{2'd0, 12'h001, 14'h0002, 6'h00, 32'h11});
    apply(1'b1, 2'd1, 32'h0020_00C5, 32'h0000_0022, 1'b0); chk("t2_s1", 96'(stall), 96'd1);
    sb.push_back('{2'd1, 12'h002, 14'h0003, 6'h05, 32'h22});
    apply(1'b1, 2'd2, 32'h8000_0FFF, 32'h0000_0033, 1'b0); chk("t2_s2", 96'(stall), 96'd1);
    sb.push_back('{2'd2, 12'h800, 14'h003F, 6'h3F, 32'h33});
    apply(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0044, 1'b0); chk("t2_s3", 96'(stall), 96'd1);
    sb.push_back('{2'd3, 12'hFFF, 14'h3FFF, 6'h3F, 32'h44});
    apply(1'b1, 2'd3, 32'h1111_1111, 32'h0000_0055, 1'b0); chk("t2_s4", 96'(stall), 96'd0);
    apply(1'b1, 2'd3, 32'h2222_2222, 32'h0000_0066, 1'b0); chk("t2_s5", 96'(stall), 96'd0);
    chk("t2_level", 96'(level), 96'd4);
    chk("t2_cnts", {rd_cnt, wr_cnt, if_cnt}, {32'd1, 32'd1, 32'd1});
    chk("t2_inv", 96'(inv_cnt), 96'd1);

    // Test 3: full with a pop in the same cycle refuses the push
    apply(1'b1, 2'd2, 32'h0000_1040, 32'h0000_0077, 1'b1);
    chk("t3_stall_full", 96'(stall), 96'd0);
    apply(1'b1, 2'd2, 32'h0000_1040, 32'h0000_0077, 1'b0);
    chk("t3_level3", 96'(level), 96'd3);
    chk("t3_stall_next", 96'(stall), 96'd1);
    sb.push_back('{2'd2, 12'h000, 14'h0041, 6'h00, 32'h77});
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t3_level4", 96'(level), 96'd4);
    repeat (4) apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t3_drained", {req_valid, level}, 96'd0);

    // Test 4: streaming with pointer wrap
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, i[1:0], 32'hFFFF_FFC0 + 32'(i), 32'hC0DE_0000 + 32'(i), 1'b1);
      chk("t4_stall", 96'(stall), 96'd1);
      sb.push_back('{i[1:0], 12'hFFF, 14'h3FFF, 6'(i), 32'hC0DE_0000 + 32'(i)});
      if (i > 0) chk("t4_level", 96'(level), 96'd1);
    end
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t4_pops", 96'(pops - p0), 96'd20);
    chk("t4_level0", 96'(level), 96'd0);

    // Test 5: head stable under backpressure, with a second push behind it
    apply(1'b1, 2'd1, 32'hABCD_E123, 32'h5A5A_5A5A, 1'b0);
    chk("t5_stall", 96'(stall), 96'd1);
    sb.push_back('{2'd1, 12'hABC, 14'h3784, 6'h23, 32'h5A5A_5A5A});
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        apply(1'b1, 2'd2, 32'h1234_5678, 32'h0000_0001, 1'b0);
        sb.push_back('{2'd2, 12'h123, 14'h1159, 6'h38, 32'h1});
      end else begin
        apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      end
      chk("t5_hold", {req_valid, req_cmd, req_tag, req_index, req_offset, req_data},
          {1'b1, 2'd1, 12'hABC, 14'h3784, 6'h23, 32'h5A5A_5A5A});
    end
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    apply(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("t5_level0", 96'(level), 96'd0);

    // Test 6: 3-bit counters saturate at 7
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1 s_valid = 1'b1; s_cmd = 2'd0;
    end
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    chk("t6_rd_sat", 96'(s_rd_cnt), 96'd7);
    chk("t6_others", {s_wr_cnt, s_if_cnt, s_inv_cnt}, 96'd0);

    chk("sb_empty", 96'(sb.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
